multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, datapath width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter CNT_W, default 64, width of the retired-instruction counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port opcode  input  7  inst[6:0] of the instruction register.
REQ-006 The block SHALL have port funct3  input  3  inst[14:12].
REQ-007 The block SHALL have port addr_lo  input  $clog2(XLEN/8)  low bits of the ALU result (effective address).
REQ-008 The block SHALL have port branch_taken  input  1  branch comparator result.
REQ-009 The block SHALL have ports im_req output 1 and im_ready input 1  instruction-memory request/ready handshake.
REQ-010 The block SHALL have ports dm_req output 1, dm_we output 1 and dm_ready input 1  data-memory request, write flag and ready.
REQ-011 The block SHALL have port dm_w_mask  output  XLEN/8  byte-write enables.
REQ-012 The block SHALL have port ir_load  output  1  instruction-register load strobe.
REQ-013 The block SHALL have ports pc_we output 1 and next_pc_sel output 1  PC write strobe; 0 selects PC+4, 1 selects ALU target.
REQ-014 The block SHALL have ports reg_w_en output 1, alu_op1_sel output 1, alu_op2_sel output 1, is_lui output 1 and wb_sel output 2  (0 ALU, 1 load data, 2 PC+4).
REQ-015 The block SHALL have ports halt output 1, illegal output 1, state output 3 and instret output CNT_W.

Function
REQ-016 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, exposed on state.
REQ-017 FETCH: im_req=1 until im_ready; ir_load=im_req&im_ready; then DECODE.
REQ-018 DECODE: one cycle. ECALL/EBREAK (opcode 1110011, funct3 000) -> HALT with illegal=0; unsupported opcode -> HALT with illegal=1; otherwise -> EXEC.
REQ-019 Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; for XLEN=64, also OP-IMM-32 and OP-32. For XLEN=32, OP-IMM-32, OP-32, LD, LWU and SD SHALL be illegal.
REQ-020 EXEC: BRANCH asserts pc_we, with next_pc_sel=branch_taken, then goes to FETCH; LOAD/STORE go to MEM; all others go to WB.
REQ-021 MEM: dm_req=1 held until dm_ready; dm_we=1 only for STORE. When dm_ready=1: a STORE asserts pc_we (next_pc_sel=0) and goes to FETCH; a LOAD goes to WB.
REQ-022 WB: reg_w_en=1 and pc_we=1 for one cycle, then FETCH; next_pc_sel=1 for JAL/JALR, else 0; wb_sel=1 for LOAD, 2 for JAL/JALR, 0 otherwise.
REQ-023 dm_w_mask SHALL be nonzero only during a STORE in MEM: SB 1<<addr_lo; SH 3<<addr_lo; SW 15<<addr_lo; SD all-ones. Bits shifted beyond width are dropped (misaligned access is not trapped).
REQ-024 alu_op1_sel=1 (PC) for AUIPC, JAL and BRANCH; alu_op2_sel=1 (imm) for every opcode except OP and OP-32; is_lui=1 for LUI. These SHALL be valid in EXEC and held through MEM/WB.
REQ-025 Minimum latency with ready tied high: BRANCH 3 cycles, STORE 4, ALU/JAL/JALR 4, LOAD 5.
REQ-026 instret SHALL increment by 1 on every cycle with pc_we=1 and wrap modulo 2^CNT_W.
REQ-027 HALT SHALL be absorbing: halt=1, illegal held, and no req, we or strobe outputs asserted; only reset exits.
REQ-028 An im_ready or dm_ready arriving outside the matching request state SHALL be ignored.
REQ-029 All other outputs SHALL be 0 in states where they are not defined above.

Reset
REQ-030 While rst_n=0, the block SHALL force state=FETCH, instret=0, halt=0, illegal=0, and all strobes and requests to 0, asynchronously, including mid-operation.
REQ-031 On the first rising edge after rst_n rises, the block SHALL assert im_req.

Verification
REQ-032 ADD (opcode 0110011), ready tied high -> FETCH, DECODE, EXEC, WB; reg_w_en and pc_we pulse in cycle 4; instret=1.
REQ-033 SW with addr_lo=4, XLEN=64, dm_ready delayed 3 cycles -> dm_req high 4 cycles; dm_w_mask=0xF0 for those cycles; no reg_w_en.
REQ-034 BEQ with branch_taken=1 -> pc_we and next_pc_sel=1 in EXEC (cycle 3); next cycle is FETCH.
REQ-035 Opcode 0000000 -> HALT, halt=1, illegal=1; im_ready pulses afterwards do not change state.
REQ-036 XLEN=32, OP-32 opcode -> illegal=1; ECALL -> halt=1, illegal=0.
REQ-037 rst_n low during MEM of a LOAD -> dm_req drops without waiting for a clock; after release, FETCH with instret=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB for an RV32/RV64
// integer core, drives memory handshakes and datapath strobes, and counts
// retired instructions (one per PC write).
module multicycle_controller #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [6:0]                   opcode,
  input  logic [2:0]                   funct3,
  input  logic [$clog2(XLEN/8)-1:0]    addr_lo,
  input  logic                         branch_taken,
  output logic                         im_req,
  input  logic                         im_ready,
  output logic                         dm_req,
  output logic                         dm_we,
  input  logic                         dm_ready,
  output logic [XLEN/8-1:0]            dm_w_mask,
  output logic                         ir_load,
  output logic                         pc_we,
  output logic                         next_pc_sel,
  output logic                         reg_w_en,
  output logic                         alu_op1_sel,
  output logic                         alu_op2_sel,
  output logic                         is_lui,
  output logic [1:0]                   wb_sel,
  output logic                         halt,
  output logic                         illegal,
  output logic [2:0]                   state,
  output logic [CNT_W-1:0]             instret
);

  localparam int MW = XLEN / 8;

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [2:0]       state_q, state_d;
  logic [6:0]       op_q;
  logic [2:0]       f3_q;
  logic             illegal_q;
  logic             run_q;
  logic [CNT_W-1:0] instret_q;
  logic             legal, is_env;
  logic             is_br, is_ld, is_st, is_jmp;
  logic [MW-1:0]    mask_base;

  // Legality of the instruction currently presented by the IR (used in DECODE)
  always_comb begin
    legal  = 1'b0;
    is_env = (opcode == OP_SYSTEM) && (funct3 == 3'd0);
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BRANCH, OP_IMM, OP_REG:   legal = 1'b1;
      OP_LOAD:                     legal = (XLEN == 64) || !((funct3 == 3'd3) || (funct3 == 3'd6));
      OP_STORE:                    legal = (XLEN == 64) || (funct3 != 3'd3);
      OP_IMM32, OP_REG32:          legal = (XLEN == 64);
      default:                     legal = 1'b0;
    endcase
  end

  // Instruction class of the latched opcode, plus the unshifted byte mask
  always_comb begin
    is_br     = (op_q == OP_BRANCH);
    is_ld     = (op_q == OP_LOAD);
    is_st     = (op_q == OP_STORE);
    is_jmp    = (op_q == OP_JAL) || (op_q == OP_JALR);
    mask_base = '0;
    case (f3_q)
      3'd0:    mask_base = MW'(1);
      3'd1:    mask_base = MW'(3);
      3'd2:    mask_base = MW'(15);
      default: mask_base = '0;
    endcase
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (run_q && im_ready) state_d = DECODE;
      DECODE:  state_d = (is_env || !legal) ? HALT : EXEC;
      EXEC:    state_d = is_br ? FETCH : ((is_ld || is_st) ? MEM : WB);
      MEM:     if (dm_ready) state_d = is_st ? FETCH : WB;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // State, latched instruction fields, halt cause, run flag and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      op_q      <= '0;
      f3_q      <= '0;
      illegal_q <= 1'b0;
      run_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == DECODE) begin
        op_q      <= opcode;
        f3_q      <= funct3;
        illegal_q <= !is_env && !legal;
      end
      if (pc_we) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Per-state datapath strobes and handshake requests
  always_comb begin
    im_req      = 1'b0;
    ir_load     = 1'b0;
    dm_req      = 1'b0;
    dm_we       = 1'b0;
    dm_w_mask   = '0;
    pc_we       = 1'b0;
    next_pc_sel = 1'b0;
    reg_w_en    = 1'b0;
    wb_sel      = 2'd0;
    halt        = 1'b0;
    alu_op1_sel = 1'b0;
    alu_op2_sel = 1'b0;
    is_lui      = 1'b0;
    case (state_q)
      // im_req waits for the first clock after reset release
      FETCH: begin
        im_req  = run_q;
        ir_load = run_q && im_ready;
      end
      EXEC: begin
        if (is_br) begin
          pc_we       = 1'b1;
          next_pc_sel = branch_taken;
        end
      end
      // SD writes the whole doubleword regardless of addr_lo
      MEM: begin
        dm_req = 1'b1;
        dm_we  = is_st;
        if (is_st) dm_w_mask = (f3_q == 3'd3) ? '1 : (mask_base << addr_lo);
        if (is_st && dm_ready) pc_we = 1'b1;
      end
      WB: begin
        reg_w_en    = 1'b1;
        pc_we       = 1'b1;
        next_pc_sel = is_jmp;
        wb_sel      = is_ld ? 2'd1 : (is_jmp ? 2'd2 : 2'd0);
      end
      HALT:    halt = 1'b1;
      default: ;
    endcase
    if ((state_q == EXEC) || (state_q == MEM) || (state_q == WB)) begin
      alu_op1_sel = (op_q == OP_AUIPC) || (op_q == OP_JAL) || is_br;
      alu_op2_sel = (op_q != OP_REG) && (op_q != OP_REG32);
      is_lui      = (op_q == OP_LUI);
    end
  end

  // Output assignments
  always_comb begin
    state   = state_q;
    illegal = illegal_q;
    instret = instret_q;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: XLEN=64 and XLEN=32 instances, random and
// directed instructions, checked each cycle against an expected state trace.
module tb_multicycle_controller;

  localparam int CW = 8;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                         JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                         ST = 7'b0100011, OPI = 7'b0010011, OPR = 7'b0110011,
                         OPI32 = 7'b0011011, OPR32 = 7'b0111011, SYS = 7'b1110011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [2:0] addr = '0;
  logic branch_taken = 1'b0, im_ready = 1'b0, dm_ready = 1'b0;
  logic sel32 = 1'b0;

  logic a_im_req, a_dm_req, a_dm_we, a_ir_load, a_pc_we, a_nps, a_rwe, a_op1, a_op2, a_lui, a_halt, a_ill;
  logic [1:0] a_wb; logic [2:0] a_st; logic [7:0] a_mask; logic [CW-1:0] a_ir;
  logic b_im_req, b_dm_req, b_dm_we, b_ir_load, b_pc_we, b_nps, b_rwe, b_op1, b_op2, b_lui, b_halt, b_ill;
  logic [1:0] b_wb; logic [2:0] b_st; logic [3:0] b_mask; logic [CW-1:0] b_ir;

  logic [13:0] obs_ctrl; logic [2:0] obs_st; logic [7:0] obs_mask; logic [CW-1:0] obs_ir;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  multicycle_controller #(.XLEN(64), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .addr_lo(addr),
    .branch_taken(branch_taken), .im_req(a_im_req), .im_ready(im_ready),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_ready(dm_ready), .dm_w_mask(a_mask),
    .ir_load(a_ir_load), .pc_we(a_pc_we), .next_pc_sel(a_nps), .reg_w_en(a_rwe),
    .alu_op1_sel(a_op1), .alu_op2_sel(a_op2), .is_lui(a_lui), .wb_sel(a_wb),
    .halt(a_halt), .illegal(a_ill), .state(a_st), .instret(a_ir));

  multicycle_controller #(.XLEN(32), .CNT_W(CW)) dut32 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .addr_lo(addr[1:0]),
    .branch_taken(branch_taken), .im_req(b_im_req), .im_ready(im_ready),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_ready(dm_ready), .dm_w_mask(b_mask),
    .ir_load(b_ir_load), .pc_we(b_pc_we), .next_pc_sel(b_nps), .reg_w_en(b_rwe),
    .alu_op1_sel(b_op1), .alu_op2_sel(b_op2), .is_lui(b_lui), .wb_sel(b_wb),
    .halt(b_halt), .illegal(b_ill), .state(b_st), .instret(b_ir));

  always_comb begin
    if (sel32) begin
      obs_ctrl = {b_im_req, b_ir_load, b_dm_req, b_dm_we, b_pc_we, b_nps, b_rwe,
                  b_op1, b_op2, b_lui, b_wb, b_halt, b_ill};
      obs_st = b_st; obs_mask = {4'b0, b_mask}; obs_ir = b_ir;
    end else begin
      obs_ctrl = {a_im_req, a_ir_load, a_dm_req, a_dm_we, a_pc_we, a_nps, a_rwe,
                  a_op1, a_op2, a_lui, a_wb, a_halt, a_ill};
      obs_st = a_st; obs_mask = a_mask; obs_ir = a_ir;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s xlen%0d t=%0t observed=%h expected=%h", tag, sel32 ? 32 : 64, $time, obs, exp);
    end
  endtask

  function automatic bit m_legal(input logic [6:0] op, input logic [2:0] f3, input bit x32);
    case (op)
      LUI, AUIPC, JAL, JALR, BR, OPI, OPR: return 1'b1;
      LD:          return !(x32 && (f3 == 3'd3 || f3 == 3'd6));
      ST:          return !(x32 && f3 == 3'd3);
      OPI32, OPR32: return !x32;
      default:     return 1'b0;
    endcase
  endfunction

  // Byte-enable pattern a store should produce at byte offset ad
  function automatic int m_mask(input logic [2:0] f3, input logic [2:0] ad, input bit x32);
    int nb, a, bytes;
    nb = x32 ? 4 : 8;
    a  = x32 ? int'(ad[1:0]) : int'(ad);
    if (f3 == 3'd3) return (1 << nb) - 1;
    bytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    return (((1 << bytes) - 1) << a) & ((1 << nb) - 1);
  endfunction

  // Present one instruction and follow its expected state trace (0=FETCH .. 5=HALT).
  // stop_at>0 abandons the trace after that many cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic tk,
                           input logic [2:0] ad, input int imd, input int dmd, input int stop_at);
    int q[$];
    int fk, mk, st;
    bit x32, lg, env, br, ld, sto, jmp, act, e_pcwe;
    logic [13:0] e_ctrl;
    logic [1:0] e_wb;
    x32 = sel32;
    lg  = m_legal(op, f3, x32);
    env = (op == SYS) && (f3 == 3'd0);
    br = (op == BR); ld = (op == LD); sto = (op == ST); jmp = (op == JAL) || (op == JALR);
    opcode = op; funct3 = f3; branch_taken = tk; addr = ad;
    for (int i = 0; i <= imd; i++) q.push_back(0);
    q.push_back(1);
    if (env || !lg) begin
      for (int i = 0; i < 4; i++) q.push_back(5);
    end else begin
      q.push_back(2);
      if (ld || sto) for (int i = 0; i <= dmd; i++) q.push_back(3);
      if (!br && !sto) q.push_back(4);
    end
    fk = 0; mk = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (stop_at > 0 && i == stop_at) break;
      @(negedge clk);
      st = q[i];
      im_ready = (st == 0) ? (fk == imd) : 1'($urandom_range(0, 1));
      dm_ready = (st == 3) ? (mk == dmd) : 1'($urandom_range(0, 1));
      #1;
      act    = (st >= 2) && (st <= 4);
      e_pcwe = (st == 2 && br) || (st == 3 && sto && dm_ready) || (st == 4);
      e_wb   = (st == 4) ? (ld ? 2'd1 : (jmp ? 2'd2 : 2'd0)) : 2'd0;
      e_ctrl = {st == 0, st == 0 && im_ready, st == 3, st == 3 && sto, e_pcwe,
                (st == 2 && br && tk) || (st == 4 && jmp), st == 4,
                act && (op == AUIPC || op == JAL || br), act && !(op == OPR || op == OPR32),
                act && (op == LUI), e_wb, st == 5, st == 5 && !lg && !env};
      chk("state", 32'(obs_st), 32'(st));
      chk("ctrl", 32'(obs_ctrl), 32'(e_ctrl));
      chk("mask", 32'(obs_mask), (st == 3 && sto) ? m_mask(f3, ad, x32) : 0);
      chk("instret", 32'(obs_ir), 32'(exp_cnt));
      if (st == 0) fk++;
      if (st == 3) mk++;
      if (e_pcwe) exp_cnt++;
    end
  endtask

  // Asynchronous reset applied off the clock edge, checked before any edge
  task automatic do_reset();
    #2;
    rst_n = 1'b0; im_ready = 1'b0; dm_ready = 1'b0;
    #1;
    chk("rst_state", 32'(obs_st), 0);
    chk("rst_ctrl", 32'(obs_ctrl), 0);
    chk("rst_mask", 32'(obs_mask), 0);
    chk("rst_instret", 32'(obs_ir), 0);
    exp_cnt = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_no_req", 32'(obs_ctrl), 0);
  endtask

  task automatic rand_legal(input bit x32);
    logic [6:0] ops [11];
    logic [6:0] op; logic [2:0] f3;
    ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, OPI32, OPR32};
    do begin
      op = ops[$urandom_range(0, x32 ? 8 : 10)];
      f3 = (op == ST) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
    end while (!m_legal(op, f3, x32));
    run_instr(op, f3, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 2), $urandom_range(0, 3), 0);
  endtask

  initial begin
    sel32 = 1'b0;
    do_reset();
    run_instr(OPR, 3'd0, 1'b0, 3'd0, 0, 0, 0);       // ADD, ready high
    run_instr(ST, 3'd2, 1'b0, 3'd4, 0, 3, 0);        // SW, mask 0xF0, dm_ready late
    run_instr(BR, 3'd0, 1'b1, 3'd0, 0, 0, 0);        // BEQ taken
    run_instr(ST, 3'd3, 1'b0, 3'd5, 1, 0, 0);        // SD ignores addr_lo
    run_instr(ST, 3'd1, 1'b0, 3'd7, 0, 1, 0);        // SH at top byte, upper bit dropped
    run_instr(LD, 3'd3, 1'b0, 3'd0, 2, 2, 0);        // LD
    run_instr(JALR, 3'd0, 1'b0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 60; i++) rand_legal(1'b0);
    for (int i = 0; i < 260; i++)                    // instret wraps past 255
      run_instr(BR, 3'd1, 1'($urandom_range(0, 1)), 3'd0, 0, 0, 0);
    run_instr(LD, 3'd2, 1'b0, 3'd0, 0, 3, 4);        // reset asserted while in MEM
    do_reset();
    run_instr(7'h00, 3'd0, 1'b0, 3'd0, 0, 0, 0);     // unsupported -> illegal halt
    do_reset();
    run_instr(SYS, 3'd0, 1'b0, 3'd0, 1, 0, 0);       // ECALL -> clean halt
    do_reset();
    run_instr(SYS, 3'd1, 1'b0, 3'd0, 0, 0, 0);       // other SYSTEM -> illegal
    do_reset();

    sel32 = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) rand_legal(1'b1);
    run_instr(ST, 3'd2, 1'b0, 3'd5, 0, 1, 0);        // SW at offset 1 -> 0xE
    run_instr(OPR32, 3'd0, 1'b0, 3'd0, 0, 0, 0);
    do_reset();
    run_instr(SYS, 3'd0, 1'b0, 3'd0, 0, 0, 0);
    do_reset();
    run_instr(LD, 3'd3, 1'b0, 3'd0, 0, 0, 0);        // LD illegal at XLEN=32
    do_reset();
    run_instr(LD, 3'd6, 1'b0, 3'd0, 0, 0, 0);        // LWU illegal at XLEN=32
    do_reset();
    run_instr(ST, 3'd3, 1'b0, 3'd0, 0, 0, 0);        // SD illegal at XLEN=32
    do_reset();
    run_instr(OPI32, 3'd0, 1'b0, 3'd0, 0, 0, 0);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
